// File: rtl/det_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | det_share_arbiter: round-robin time-sharing of one 1101 Moore detector   |
// | among N_REQ serial bit sources, with per-frame hit report.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module det_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             Clock,
  input  logic             Rn,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] w_in,
  output logic [N_REQ-1:0] gnt,
  output logic             bit_en,
  output logic [2:0]       owner,
  output logic             det_R,
  output logic             det_w,
  input  logic             det_Z,
  output logic             done,
  output logic             hit
);

  localparam int                 c_IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0]   c_LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_owner;
  logic [2:0]         w_owner_nxt;
  logic [c_IDX_W-1:0] r_ptr;
  logic [c_IDX_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_drain;
  logic               w_drain_nxt;
  logic               r_hit;
  logic               w_hit_nxt;

  logic [c_IDX_W-1:0] w_idx;
  logic [c_IDX_W-1:0] w_pick;
  logic               w_pick_vld;
  logic               w_own_req;
  logic               w_in_frame;

  assign w_idx      = r_owner[c_IDX_W-1:0];
  assign w_own_req  = req[w_idx];
  assign w_in_frame = (r_state == S_CLEAR) || (r_state == S_STREAM) || (r_state == S_DRAIN);

  // Scan from ptr+N down to ptr+1 so the nearest requester after ptr wins last.
  always_comb begin
    int j;
    j          = 0;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = int'(r_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j[c_IDX_W-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = j[c_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    w_hit_nxt   = r_hit;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_owner_nxt = 3'(w_pick);
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_hit_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_drain_nxt = 1'b0;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (det_Z) w_hit_nxt = 1'b1;
        if (r_cnt == c_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (det_Z) w_hit_nxt = 1'b1;
        w_drain_nxt = 1'b1;
        if (r_drain) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        w_ptr_nxt   = w_idx;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Owner withdrawing its request abandons the frame silently.
    if (w_in_frame && !w_own_req) begin
      w_state_nxt = S_IDLE;
      w_hit_nxt   = 1'b0;
      w_ptr_nxt   = w_idx;
    end
  end

  always_ff @(posedge Clock or negedge Rn) begin
    if (!Rn) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= c_PTR_RST;
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
      r_hit   <= w_hit_nxt;
    end
  end

  always_comb begin
    gnt    = '0;
    bit_en = 1'b0;
    det_R  = 1'b1;
    det_w  = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_CLEAR: gnt[w_idx] = 1'b1;
      S_STREAM: begin
        gnt[w_idx] = 1'b1;
        bit_en     = 1'b1;
        det_R      = 1'b0;
        det_w      = w_in[w_idx];
      end
      S_DRAIN: begin
        gnt[w_idx] = 1'b1;
        det_R      = 1'b0;
      end
      S_REPORT: done = 1'b1;
      default: ;
    endcase
  end

  assign owner = r_owner;
  assign hit   = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_det_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_det_share_arbiter: self-checking bench with a behavioural 1101        |
// | detector (registered Z) and a scoreboard of per-frame owner/hit results. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_det_share_arbiter;

  localparam int N_REQ     = 4;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic             Clock = 1'b0;
  logic             Rn    = 1'b0;
  logic [N_REQ-1:0] req   = '0;
  logic [N_REQ-1:0] w_in  = '0;
  logic [N_REQ-1:0] gnt;
  logic             bit_en, det_R, det_w, det_Z, done, hit;
  logic [2:0]       owner;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [2:0] own;
    logic       hit_b;
  } exp_t;
  exp_t sb[$];

  logic [FRAME_LEN-1:0]         pat [N_REQ];
  logic [$clog2(FRAME_LEN)-1:0] bidx = '0;
  logic [2:0]                   d_s  = 3'd0;
  logic                         d_z  = 1'b0;

  det_share_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Rn(Rn), .req(req), .w_in(w_in), .gnt(gnt), .bit_en(bit_en),
    .owner(owner), .det_R(det_R), .det_w(det_w), .det_Z(det_Z), .done(done), .hit(hit)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // External detector: Moore 1101, sticky, output register adds one cycle.
  always @(posedge Clock) begin
    if (det_R) begin
      d_s <= 3'd0;
      d_z <= 1'b0;
    end else begin
      d_z <= (d_s == 3'd4);
      case (d_s)
        3'd0:    d_s <= det_w ? 3'd1 : 3'd0;
        3'd1:    d_s <= det_w ? 3'd2 : 3'd0;
        3'd2:    d_s <= det_w ? 3'd2 : 3'd3;
        3'd3:    d_s <= det_w ? 3'd4 : 3'd0;
        default: d_s <= 3'd4;
      endcase
    end
  end
  assign det_Z = d_z;

  // Owner serializer: bit k of pat[] is the k-th bit presented.
  always @(negedge Clock) begin
    if (bit_en) begin
      w_in[owner[1:0]] = pat[owner[1:0]][bidx];
      bidx = bidx + 1'b1;
    end else begin
      w_in = '0;
      bidx = '0;
    end
  end

  function automatic logic exp_hit(input logic [FRAME_LEN-1:0] p);
    exp_hit = 1'b0;
    for (int k = 0; k <= FRAME_LEN - 4; k++)
      if (p[k] && p[k+1] && !p[k+2] && p[k+3]) exp_hit = 1'b1;
  endfunction

  task automatic apply_reset();
    Rn  = 1'b0;
    req = '0;
    repeat (3) @(negedge Clock);
    Rn = 1'b1;
  endtask

  task automatic wait_done(input int budget, input logic [N_REQ-1:0] gexp,
                           output bit seen, output int at, output int ngnt, output int nfor,
                           output logic [2:0] own_s, output logic hit_s);
    seen = 1'b0; at = 0; ngnt = 0; nfor = 0; own_s = '0; hit_s = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge Clock);
      if (gnt == gexp) ngnt++;
      if (((gnt & ~gexp) != '0) || ($countones(gnt) > 1)) nfor++;
      if (done) begin
        seen  = 1'b1;
        at    = cyc;
        own_s = owner;
        hit_s = hit;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    n_cmp++; if (det_R !== 1'b1) begin n_err++; $display("FAIL rst_detR: got %b want 1", det_R); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (owner !== 3'd0) begin n_err++; $display("FAIL rst_owner: got %0d want 0", owner); end
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %b want 0", hit); end
    n_cmp++; if (bit_en !== 1'b0) begin n_err++; $display("FAIL rst_biten: got %b want 0", bit_en); end
  endtask

  task automatic test_single_hit();
    bit seen; int at, c0, ngnt, nfor; logic [2:0] own_s; logic hit_s; exp_t e;
    pat[0] = 8'b0000_1011;
    @(negedge Clock);
    req = 4'b0001;
    c0  = cyc;
    e.own = 3'd0; e.hit_b = exp_hit(pat[0]);
    sb.push_back(e);
    wait_done(30, 4'b0001, seen, at, ngnt, nfor, own_s, hit_s);
    e = sb.pop_front();
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL hit_done_seen: got %b want 1", seen); end
    n_cmp++; if (at - c0 != 12) begin n_err++; $display("FAIL hit_done_latency: got %0d want 12", at - c0); end
    n_cmp++; if (ngnt != 11) begin n_err++; $display("FAIL hit_gnt_cycles: got %0d want 11", ngnt); end
    n_cmp++; if (hit_s !== e.hit_b) begin n_err++; $display("FAIL hit_result: got %b want %b", hit_s, e.hit_b); end
    n_cmp++; if (own_s !== e.own) begin n_err++; $display("FAIL hit_owner: got %0d want %0d", own_s, e.own); end
    req = '0;
    @(negedge Clock);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL hit_held_idle: got %b want 1", hit); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL hit_gnt_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_no_hit();
    bit seen, found; int at, ngnt, nfor; logic [2:0] own_s; logic hit_s; exp_t e;
    logic prev_r; logic [N_REQ-1:0] prev_g;
    pat[0] = '0;
    @(negedge Clock);
    req = 4'b0001;
    e.own = 3'd0; e.hit_b = exp_hit(pat[0]);
    sb.push_back(e);
    found = 1'b0; prev_r = 1'b0; prev_g = '0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge Clock);
      if (bit_en) found = 1'b1;
      else begin prev_r = det_R; prev_g = gnt; end
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL nohit_biten_seen: got %b want 1", found); end
    n_cmp++; if (prev_r !== 1'b1) begin n_err++; $display("FAIL nohit_clear_detR: got %b want 1", prev_r); end
    n_cmp++; if (prev_g !== 4'b0001) begin n_err++; $display("FAIL nohit_clear_gnt: got %b want 0001", prev_g); end
    n_cmp++; if (det_R !== 1'b0) begin n_err++; $display("FAIL nohit_stream_detR: got %b want 0", det_R); end
    wait_done(20, 4'b0001, seen, at, ngnt, nfor, own_s, hit_s);
    e = sb.pop_front();
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL nohit_done_seen: got %b want 1", seen); end
    n_cmp++; if (hit_s !== e.hit_b) begin n_err++; $display("FAIL nohit_result: got %b want %b", hit_s, e.hit_b); end
    req = '0;
  endtask

  task automatic test_round_robin();
    bit seen; int at, prev_at, ngnt, nfor, nfor_tot; logic [2:0] own_s; logic hit_s; exp_t e;
    logic [N_REQ-1:0] gexp;
    pat[0] = 8'b0000_1011;
    pat[1] = 8'b1011_0000;
    pat[2] = 8'b0001_0111;
    pat[3] = 8'b0011_0101;
    apply_reset();
    nfor_tot = 0; prev_at = 0;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      e.own = 3'(f % N_REQ); e.hit_b = exp_hit(pat[f % N_REQ]);
      sb.push_back(e);
      gexp = '0; gexp[f % N_REQ] = 1'b1;
      wait_done(20, gexp, seen, at, ngnt, nfor, own_s, hit_s);
      nfor_tot += nfor;
      e = sb.pop_front();
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rr_done_seen[%0d]: got %b want 1", f, seen); end
      n_cmp++; if (own_s !== e.own) begin n_err++; $display("FAIL rr_owner[%0d]: got %0d want %0d", f, own_s, e.own); end
      n_cmp++; if (hit_s !== e.hit_b) begin n_err++; $display("FAIL rr_hit[%0d]: got %b want %b", f, hit_s, e.hit_b); end
      n_cmp++; if (ngnt != 11) begin n_err++; $display("FAIL rr_gnt_cycles[%0d]: got %0d want 11", f, ngnt); end
      if (f > 0) begin
        n_cmp++; if (at - prev_at != 13) begin n_err++; $display("FAIL rr_done_period[%0d]: got %0d want 13", f, at - prev_at); end
      end
      prev_at = at;
      if (f == 4) req = '0;
    end
    n_cmp++; if (nfor_tot != 0) begin n_err++; $display("FAIL rr_gnt_onehot: got %0d bad cycles want 0", nfor_tot); end
  endtask

  task automatic test_abort();
    bit found; int nb, ng, ndone;
    @(negedge Clock);
    req = 4'b0010;
    nb = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge Clock);
      if (bit_en) nb++;
      if (nb == 3) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL abort_stream_reached: got %b want 1", found); end
    req = '0;
    @(negedge Clock);
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL abort_gnt: got %b want 0000", gnt); end
    n_cmp++; if (bit_en !== 1'b0) begin n_err++; $display("FAIL abort_biten: got %b want 0", bit_en); end
    ndone = 0;
    repeat (20) begin @(negedge Clock); if (done) ndone++; end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL abort_no_done: got %0d dones want 0", ndone); end
    // Abort in the first drain cycle after a hit has been latched.
    pat[1] = 8'b0000_1011;
    req = 4'b0010;
    ng = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge Clock);
      if (gnt != '0) ng++;
      if (ng == 10) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL abort2_drain_reached: got %b want 1", found); end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL abort2_hit_before: got %b want 1", hit); end
    n_cmp++; if (owner !== 3'd1) begin n_err++; $display("FAIL abort2_owner: got %0d want 1", owner); end
    req = '0;
    @(negedge Clock);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL abort2_hit_cleared: got %b want 0", hit); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL abort2_gnt: got %b want 0000", gnt); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort2_done: got %b want 0", done); end
  endtask

  task automatic test_late_request_and_reset();
    bit seen, found; int at, ngnt, nfor, nb, ndone; logic [2:0] own_s; logic hit_s; exp_t e;
    pat[0] = 8'b0011_0101;
    pat[2] = 8'b0001_0111;
    @(negedge Clock);
    req = 4'b0001;
    e.own = 3'd0; e.hit_b = exp_hit(pat[0]);
    sb.push_back(e);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge Clock);
      if (gnt == 4'b0001) found = 1'b1;
    end
    repeat (3) @(negedge Clock);
    req = 4'b0101;
    wait_done(20, 4'b0001, seen, at, ngnt, nfor, own_s, hit_s);
    e = sb.pop_front();
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL late_done_seen: got %b want 1", seen); end
    n_cmp++; if (own_s !== e.own) begin n_err++; $display("FAIL late_owner: got %0d want %0d", own_s, e.own); end
    n_cmp++; if (hit_s !== e.hit_b) begin n_err++; $display("FAIL late_hit: got %b want %b", hit_s, e.hit_b); end
    n_cmp++; if (nfor != 0) begin n_err++; $display("FAIL late_no_preempt: got %0d foreign gnt cycles want 0", nfor); end
    req = 4'b0100;
    @(negedge Clock);
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL late_idle_gnt: got %b want 0000", gnt); end
    @(negedge Clock);
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL late_gnt2: got %b want 0100", gnt); end
    n_cmp++; if (owner !== 3'd2) begin n_err++; $display("FAIL late_owner2: got %0d want 2", owner); end
    nb = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge Clock);
      if (bit_en) nb++;
      if (nb == 4) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rstmid_stream_reached: got %b want 1", found); end
    Rn = 1'b0;
    #1;
    n_cmp++; if ({gnt, bit_en, det_R, done, hit} !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rstmid_outputs: got gnt=%b bit_en=%b det_R=%b done=%b hit=%b want 0000 0 1 0 0",
                        gnt, bit_en, det_R, done, hit);
    end
    n_cmp++; if (owner !== 3'd0) begin n_err++; $display("FAIL rstmid_owner: got %0d want 0", owner); end
    req = '0;
    repeat (2) @(negedge Clock);
    Rn = 1'b1;
    ndone = 0;
    repeat (20) begin @(negedge Clock); if (done) ndone++; end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d dones want 0", ndone); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) pat[i] = '0;
    test_reset();
    test_single_hit();
    test_no_hit();
    test_round_robin();
    test_abort();
    test_late_request_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
